// File: rtl/mips_branch_pkg.sv
// mips_branch_pkg: branch type/state encodings and helpers shared by the branch resolver.
package mips_branch_pkg;
    typedef enum logic [3:0] {
        BR_BEQ = 4'd0,
        BR_BNE = 4'd1,
        BR_BLT = 4'd2,
        BR_BGE = 4'd3,
        BR_BGT = 4'd4,
        BR_BLE = 4'd5,
        BR_J   = 4'd6,
        BR_JAL = 4'd7
    } br_type_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_REDIRECT
    } br_state_e;

    localparam int BR_OFFSET_SHIFT = 2;

    function automatic logic is_br_type(logic [3:0] t);
        return t < 4'd8;
    endfunction

    function automatic logic is_jump(logic [3:0] t);
        return t == BR_J || t == BR_JAL;
    endfunction
endpackage

// File: rtl/branch_cond_eval.sv
// branch_cond_eval: decides taken/illegal from branch type and comparator flags.
module branch_cond_eval
    import mips_branch_pkg::*;
(
    input  logic [3:0] i_br_type,
    input  logic       i_cmp_l,
    input  logic       i_cmp_e,
    input  logic       i_cmp_g,
    input  logic       i_cmp_n,
    output logic       o_taken,
    output logic       o_illegal
);
    logic w_legal;
    logic w_jump;
    logic w_cond;

    // exactly one of L/E/G, and N must be the complement of E
    assign w_legal = (i_cmp_l ^ i_cmp_e ^ i_cmp_g) & ~(i_cmp_l & i_cmp_e & i_cmp_g)
                   & (i_cmp_n == ~i_cmp_e);
    assign w_jump  = is_jump(i_br_type);

    always_comb begin
        w_cond = 1'b0;
        case (i_br_type)
            BR_BEQ:  w_cond = i_cmp_e;
            BR_BNE:  w_cond = i_cmp_n;
            BR_BLT:  w_cond = i_cmp_l;
            BR_BGE:  w_cond = i_cmp_g | i_cmp_e;
            BR_BGT:  w_cond = i_cmp_g;
            BR_BLE:  w_cond = i_cmp_l | i_cmp_e;
            default: w_cond = 1'b0;
        endcase
    end

    assign o_taken   = w_jump | (w_cond & w_legal);
    assign o_illegal = ~w_jump & ~w_legal;
endmodule

// File: rtl/branch_resolver.sv
// branch_resolver: ID-stage branch/jump resolution with operand-wait stall, registered redirect and perf counters.
module branch_resolver
    import mips_branch_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_br_valid,
    input  logic [3:0]       i_br_type,
    input  logic             i_operands_ready,
    input  logic             i_cmp_l,
    input  logic             i_cmp_e,
    input  logic             i_cmp_g,
    input  logic             i_cmp_n,
    input  logic [XLEN-1:0]  i_pc_plus4,
    input  logic [15:0]      i_imm,
    input  logic [25:0]      i_jtarget,
    output logic             o_stall,
    output logic             o_redirect_valid,
    output logic [XLEN-1:0]  o_redirect_pc,
    output logic             o_flush,
    output logic             o_flag_err,
    output logic [CNT_W-1:0] o_branch_cnt,
    output logic [CNT_W-1:0] o_taken_cnt
);
    br_state_e        r_state;
    logic             r_redirect_valid;
    logic             r_flush;
    logic             r_flag_err;
    logic [XLEN-1:0]  r_redirect_pc;
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_taken_cnt;

    logic             w_br;
    logic             w_resolve;
    logic             w_taken;
    logic             w_illegal;
    logic [XLEN-1:0]  w_sext;
    logic [XLEN-1:0]  w_target;

    branch_cond_eval u_eval (
        .i_br_type (i_br_type),
        .i_cmp_l   (i_cmp_l),
        .i_cmp_e   (i_cmp_e),
        .i_cmp_g   (i_cmp_g),
        .i_cmp_n   (i_cmp_n),
        .o_taken   (w_taken),
        .o_illegal (w_illegal)
    );

    // the slot right after a redirect is wrong-path, so branches there are ignored
    assign w_br      = i_br_valid & is_br_type(i_br_type) & (r_state != ST_REDIRECT);
    assign w_resolve = w_br & i_operands_ready;
    assign o_stall   = w_br & ~i_operands_ready;

    assign w_sext   = {{(XLEN-16){i_imm[15]}}, i_imm};
    assign w_target = is_jump(i_br_type) ? {i_pc_plus4[XLEN-1:28], i_jtarget, 2'b00}
                                         : i_pc_plus4 + (w_sext << BR_OFFSET_SHIFT);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state          <= ST_IDLE;
            r_redirect_valid <= 1'b0;
            r_flush          <= 1'b0;
            r_flag_err       <= 1'b0;
            r_redirect_pc    <= '0;
            r_branch_cnt     <= '0;
            r_taken_cnt      <= '0;
        end else begin
            r_state          <= w_resolve ? (w_taken ? ST_REDIRECT : ST_IDLE)
                                          : (o_stall ? ST_WAIT : ST_IDLE);
            r_redirect_valid <= w_resolve & w_taken;
            r_flush          <= w_resolve & w_taken;
            if (w_resolve) begin
                r_branch_cnt <= r_branch_cnt + {{(CNT_W-1){1'b0}}, ~&r_branch_cnt};
                r_flag_err   <= r_flag_err | w_illegal;
            end
            if (w_resolve && w_taken) begin
                r_redirect_pc <= w_target;
                r_taken_cnt   <= r_taken_cnt + {{(CNT_W-1){1'b0}}, ~&r_taken_cnt};
            end
        end
    end

    assign o_redirect_valid = r_redirect_valid;
    assign o_redirect_pc    = r_redirect_pc;
    assign o_flush          = r_flush;
    assign o_flag_err       = r_flag_err;
    assign o_branch_cnt     = r_branch_cnt;
    assign o_taken_cnt      = r_taken_cnt;
endmodule

// File: tb/tb_branch_resolver.sv
// tb_branch_resolver: directed checks of branch_resolver with narrow counters so saturation is reachable.
module tb_branch_resolver;
    import mips_branch_pkg::*;

    localparam int XLEN  = 32;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             br_valid;
    logic [3:0]       br_type;
    logic             operands_ready;
    logic             cmp_l, cmp_e, cmp_g, cmp_n;
    logic [XLEN-1:0]  pc_plus4;
    logic [15:0]      imm;
    logic [25:0]      jtarget;
    logic             stall, redirect_valid, flush, flag_err;
    logic [XLEN-1:0]  redirect_pc;
    logic [CNT_W-1:0] branch_cnt, taken_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_resolver #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_br_valid       (br_valid),
        .i_br_type        (br_type),
        .i_operands_ready (operands_ready),
        .i_cmp_l          (cmp_l),
        .i_cmp_e          (cmp_e),
        .i_cmp_g          (cmp_g),
        .i_cmp_n          (cmp_n),
        .i_pc_plus4       (pc_plus4),
        .i_imm            (imm),
        .i_jtarget        (jtarget),
        .o_stall          (stall),
        .o_redirect_valid (redirect_valid),
        .o_redirect_pc    (redirect_pc),
        .o_flush          (flush),
        .o_flag_err       (flag_err),
        .o_branch_cnt     (branch_cnt),
        .o_taken_cnt      (taken_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // flags packed as {L,E,G,N}
    task automatic drv(input logic [3:0] t, input logic rdy, input logic [3:0] f,
                       input logic [31:0] pc, input logic [15:0] im, input logic [25:0] jt);
        br_valid = 1'b1;
        br_type = t;
        operands_ready = rdy;
        {cmp_l, cmp_e, cmp_g, cmp_n} = f;
        pc_plus4 = pc;
        imm = im;
        jtarget = jt;
        #1;
    endtask

    task automatic redir(input string tag, input logic rv, input logic [31:0] pc);
        chk({tag, "_rv"}, 32'(redirect_valid), 32'(rv));
        chk({tag, "_fl"}, 32'(flush), 32'(rv));
        if (rv) chk({tag, "_pc"}, redirect_pc, pc);
    endtask

    task automatic cnts(input string tag, input int b, input int t);
        chk({tag, "_bc"}, 32'(branch_cnt), 32'(b));
        chk({tag, "_tc"}, 32'(taken_cnt), 32'(t));
    endtask

    initial begin
        rst = 1'b1;
        br_valid = 1'b0;
        br_type = 4'd0;
        operands_ready = 1'b0;
        {cmp_l, cmp_e, cmp_g, cmp_n} = 4'b0;
        pc_plus4 = '0;
        imm = '0;
        jtarget = '0;
        step();
        step();
        chk("rst_stall", 32'(stall), 0);
        redir("rst", 1'b0, 0);
        chk("rst_pc", redirect_pc, 0);
        chk("rst_err", 32'(flag_err), 0);
        cnts("rst", 0, 0);
        rst = 1'b0;
        step();

        // BEQ taken
        drv(BR_BEQ, 1'b1, 4'b0100, 32'h0040_0004, 16'h0003, 26'h0);
        chk("beq_stall", 32'(stall), 0);
        step();
        br_valid = 1'b0;
        redir("beq", 1'b1, 32'h0040_0010);
        cnts("beq", 1, 1);
        step();
        redir("beq_end", 1'b0, 0);

        // BLT not taken (G set)
        drv(BR_BLT, 1'b1, 4'b0011, 32'h0000_1000, 16'h0010, 26'h0);
        chk("blt_stall", 32'(stall), 0);
        step();
        br_valid = 1'b0;
        redir("blt", 1'b0, 0);
        cnts("blt", 2, 1);

        // BNE waits 3 cycles for operands, then taken to pc_plus4-4
        drv(BR_BNE, 1'b0, 4'b1001, 32'h0000_0100, 16'hFFFF, 26'h0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bne_stall%0d", i), 32'(stall), 1);
            step();
            chk($sformatf("bne_norv%0d", i), 32'(redirect_valid), 0);
        end
        operands_ready = 1'b1;
        #1;
        chk("bne_res_stall", 32'(stall), 0);
        step();
        redir("bne", 1'b1, 32'h0000_00FC);
        cnts("bne", 3, 2);
        // wrong-path branch in the redirect slot: no stall, no count
        drv(BR_BEQ, 1'b0, 4'b0100, 32'h0, 16'h0, 26'h0);
        chk("wp_stall", 32'(stall), 0);
        step();
        redir("wp", 1'b0, 0);
        cnts("wp", 3, 2);
        chk("wp_idle_stall", 32'(stall), 1);
        br_valid = 1'b0;
        step();

        // BGE taken with negative wrap
        drv(BR_BGE, 1'b1, 4'b0100, 32'h0000_0004, 16'h8000, 26'h0);
        step();
        br_valid = 1'b0;
        redir("wrap", 1'b1, 32'hFFFE_0004);
        step();

        // J ignores flags, even illegal ones
        drv(BR_J, 1'b1, 4'b1100, 32'h9000_0000, 16'h0, 26'h3FF_FFFF);
        step();
        br_valid = 1'b0;
        redir("j", 1'b1, 32'h9FFF_FFFC);
        chk("j_err", 32'(flag_err), 0);
        cnts("j", 5, 4);
        step();

        drv(BR_JAL, 1'b1, 4'b0001, 32'h0000_0010, 16'h0, 26'h000_0001);
        step();
        br_valid = 1'b0;
        redir("jal", 1'b1, 32'h0000_0004);
        cnts("jal", 6, 5);
        step();

        // reserved code: no stall, no count
        drv(4'hA, 1'b0, 4'b0100, 32'h0, 16'h0, 26'h0);
        chk("rsv_stall", 32'(stall), 0);
        step();
        br_valid = 1'b0;
        redir("rsv", 1'b0, 0);
        cnts("rsv", 6, 5);

        // BLE with L and E both set: illegal, not taken, sticky error
        drv(BR_BLE, 1'b1, 4'b1100, 32'h0000_2000, 16'h0004, 26'h0);
        step();
        br_valid = 1'b0;
        redir("ble", 1'b0, 0);
        chk("ble_err", 32'(flag_err), 1);
        cnts("ble", 7, 5);
        step();
        chk("ble_err_hold", 32'(flag_err), 1);

        // back-to-back: not-taken then taken on the next cycle
        drv(BR_BGT, 1'b1, 4'b1001, 32'h0000_3000, 16'h0001, 26'h0);
        step();
        redir("b2b_nt", 1'b0, 0);
        drv(BR_BGT, 1'b1, 4'b0011, 32'h0000_3000, 16'h0001, 26'h0);
        step();
        br_valid = 1'b0;
        redir("b2b_t", 1'b1, 32'h0000_3004);
        cnts("b2b", 9, 6);
        step();

        // async reset in the middle of a redirect
        drv(BR_BEQ, 1'b1, 4'b0100, 32'h0000_4000, 16'h0002, 26'h0);
        step();
        br_valid = 1'b0;
        redir("pre_rst", 1'b1, 32'h0000_4008);
        rst = 1'b1;
        #1;
        redir("arst", 1'b0, 0);
        chk("arst_pc", redirect_pc, 0);
        chk("arst_err", 32'(flag_err), 0);
        chk("arst_stall", 32'(stall), 0);
        cnts("arst", 0, 0);
        step();
        rst = 1'b0;
        step();

        // saturate: br_valid held, so each taken is followed by an ignored slot
        drv(BR_BEQ, 1'b1, 4'b0100, 32'h0000_0100, 16'h0001, 26'h0);
        for (int i = 0; i < 255; i++) begin
            step();
            step();
        end
        cnts("sat_fill", 255, 255);
        step();
        redir("sat", 1'b1, 32'h0000_0104);
        cnts("sat", 255, 255);
        br_valid = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/branch_resolver.md
# branch_resolver

Resolves conditional branches and jumps in the ID stage of the MIPS pipeline. It consumes the L/E/G/N flags of the rs/rt comparator, decides taken/not-taken, and computes the target. It stalls IF/ID while operands are not yet forwarded, then issues a one-cycle registered redirect and flush to fetch. Saturating branch/taken counters feed the performance readout.

## Interface
- XLEN, 32, datapath/PC width
- CNT_W, 16, width of saturating performance counters

- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- br_valid  in  1  ID holds a branch/jump this cycle
- br_type  in  4  br_type_e: BEQ, BNE, BLT, BGE, BGT, BLE, J, JAL; other codes reserved
- operands_ready  in  1  forwarding unit: rs/rt final values present at comparator
- cmp_l, cmp_e, cmp_g, cmp_n  in  1 each  comparator flags (signed rs vs rt)
- pc_plus4  in  XLEN  PC of branch + 4
- imm  in  16  branch offset, words, signed
- jtarget  in  26  J-format target field
- stall  out  1  hold PC and IF/ID
- redirect_valid  out  1  fetch must load redirect_pc
- redirect_pc  out  XLEN  taken target
- flush  out  1  squash instruction in IF/ID
- flag_err  out  1  sticky: illegal flag combination seen
- branch_cnt, taken_cnt  out  CNT_W each  resolved / taken counts

## Operation
- FSM states: IDLE, WAIT, REDIRECT.
- IDLE: br_valid & !operands_ready -> WAIT, stall=1 (combinational). br_valid & operands_ready -> resolve this cycle; taken -> REDIRECT, not-taken -> stay IDLE.
- WAIT: stall=1 while !operands_ready. When operands_ready, resolve that cycle with stall=0. br_valid/br_type/imm are held stable by the stall.
- REDIRECT: one cycle, redirect_valid=1, flush=1, stall=0. Then IDLE. br_valid in this cycle is wrong-path and is ignored: not resolved, not counted.
- Conditions: BEQ=E, BNE=N, BLT=L, BGE=G|E, BGT=G, BLE=L|E, J/JAL always taken (flags ignored).
- Branch target = pc_plus4 + (sext(imm) << 2), modulo 2^XLEN (wraps silently). Jump target = {pc_plus4[31:28], jtarget, 2'b00}.
- Legal flags: exactly one of L/E/G set and N == !E. For a conditional branch with illegal flags: resolve not-taken, set flag_err (cleared only by rst). Still counted in branch_cnt.
- Reserved br_type with br_valid: treated as no branch, not counted.
- Counters: branch_cnt +1 per resolution, taken_cnt +1 per taken; both saturate at 2^CNT_W-1.

## Timing
- Reset (async, any state): state=IDLE; stall, redirect_valid, flush, flag_err=0; redirect_pc=0; counters=0. Effect is immediate, including mid-WAIT or mid-REDIRECT.
- stall is combinational from state/br_valid/operands_ready.
- redirect_valid, redirect_pc, and flush are registered: asserted exactly the cycle after resolution, for one cycle.
- Resolve-to-redirect latency is 1 cycle. WAIT adds one cycle per cycle of !operands_ready.
- Back-to-back: a branch resolved not-taken allows the next br_valid to resolve on the following cycle.
- Counters update on the clock edge ending the resolution cycle.

## Structure
- Package mips_branch_pkg: br_type_e enum (4-bit codes), br_state_e enum, BR_OFFSET_SHIFT=2.
- Sub-module branch_cond_eval: combinational evaluator taking br_type and flags; outputs taken and illegal. The FSM, target adder, and counters live in branch_resolver.

## Test plan
- BEQ, flags E=1/N=0, operands_ready=1, pc_plus4=0x0040_0004, imm=0x0003 -> next cycle redirect_valid=1, flush=1, redirect_pc=0x0040_0010; branch_cnt=1, taken_cnt=1.
- BLT, flags G=1, ready -> no redirect, no stall; branch_cnt=1, taken_cnt=0.
- BNE with operands_ready low for 3 cycles -> stall=1 for exactly those 3 cycles; resolve on cycle 4; redirect on cycle 5.
- imm=0x8000, pc_plus4=0x0000_0004 -> redirect_pc=0xFFFE_0004 (wrap). J with jtarget=0x3FF_FFFF, pc_plus4=0x9000_0000 -> 0x9FFF_FFFC.
- Flags L=1,E=1 on BLE -> not taken, flag_err=1 and held; assert rst mid-REDIRECT -> all outputs 0 immediately.
- Preload counters to 0xFFFF via 65535 taken branches -> next taken leaves both at 0xFFFF; br_valid during REDIRECT is not counted.
